cpu_mem_responder: RTL and testbench

- Memory-side responder for the CPU's multicycle memory interface. The CPU control unit acts as the initiator, issuing read and write requests; this block completes them after a programmable number of wait states.
- Holds a DEPTH x DATA_W word array and answers each request with a single-cycle ack. Out-of-range addresses are flagged on err.
- Sits between the CPU datapath's memory port and the program/data store. It replaces the zero-latency internal memory so the control unit can be exercised against real wait states.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/resp_mem_array.sv | 45 ++++
 rtl/cpu_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU memory interface: the natural address and
// word widths used by the CPU datapath and the memory responder, the width
// of the responder's wait-state counter, and the responder FSM state type.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;

    // Wait-state counter width; large enough for 0..15 wait states.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/resp_mem_array.sv
// ---------------------------------------------------------------------------
// resp_mem_array
// Single-port DEPTH x DATA_W synchronous word store with registered read.
// Contents are never reset. The read register only loads on a read access
// (en=1, we=0), so it holds its value across writes and idle cycles.
//
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable
//   we     in   1 = write wdata to addr, 0 = read addr into rdata
//   addr   in   word address (caller guarantees addr < DEPTH when en=1)
//   wdata  in   write data
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module resp_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = 200
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= wdata;
            end else begin
                rdata_reg <= mem_array[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
// Memory-side responder for the CPU's multicycle memory interface. A request
// is captured in IDLE, held for WAIT_CYC wait states, performed against the
// word array on the edge that enters RESP, and acknowledged with a one-cycle
// ack pulse on the edge that leaves RESP. Out-of-range addresses do not touch
// the array, return zero read data and raise err alongside ack.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active low
//   req    in   request strobe (sampled only in IDLE)
//   wr     in   1 = write, 0 = read
//   addr   in   word address
//   wdata  in   write data
//   ack    out  one-cycle completion pulse
//   rdata  out  read data; held until the next read completion or reset
//   err    out  address error, qualified by ack
//   busy   out  transaction in flight (accept+1 until ack drops)
// ---------------------------------------------------------------------------
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int DEPTH    = 200,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    generate
        if (WAIT_CYC < 0 || WAIT_CYC > 15 || DEPTH < 1 ||
            64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_param_check
            $error("cpu_mem_responder: illegal WAIT_CYC or DEPTH");
        end
    endgenerate

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYC);
    localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_reg;
    logic              err_reg;
    logic              busy_reg;
    // When set, rdata reads as zero (after reset or an out-of-range access)
    // instead of the array's read register.
    logic              rdata_zero_reg;

    logic              accept;
    logic              resp_entry;
    logic              op_wr;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              op_in_range;
    logic              addr_q_in_range;
    logic              mem_en;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        accept     = (state_reg == IDLE) && req;
        resp_entry = (accept && (WAIT_CYC == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == CNT_W'(1)));
        // With zero wait states RESP is entered on the accept edge itself,
        // so the operation must come straight from the request inputs.
        if (state_reg == IDLE) begin
            op_wr    = wr;
            op_addr  = addr;
            op_wdata = wdata;
        end else begin
            op_wr    = wr_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
        op_in_range     = 32'(op_addr) < DEPTH_U;
        addr_q_in_range = 32'(addr_q) < DEPTH_U;
        // Gated by rst so a reset on the would-be RESP edge discards the op.
        mem_en = rst && resp_entry && op_in_range;
    end

    resp_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (op_wr),
        .addr  (op_addr),
        .wdata (op_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            rdata_zero_reg <= 1'b1;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;

            if (resp_entry) begin
                if (!op_in_range) begin
                    rdata_zero_reg <= 1'b1;
                end else if (!op_wr) begin
                    rdata_zero_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    // Also covers the ack cycle: busy stays high only if a
                    // new request is accepted on the edge that drops ack.
                    busy_reg <= req;
                    if (req) begin
                        wr_q      <= wr;
                        addr_q    <= addr;
                        wdata_q   <= wdata;
                        cnt_reg   <= WAIT_CNT;
                        state_reg <= (WAIT_CYC == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    ack_reg   <= 1'b1;
                    err_reg   <= !addr_q_in_range;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack   = ack_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;
    assign rdata = rdata_zero_reg ? '0 : mem_rdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
// Scoreboard bench. The stimulus process computes each transaction's
// expected response from a word-array reference model and queues it; an
// independent monitor pops and compares whenever ack is seen. A second
// instance with zero wait states exercises back-to-back requests.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 200;
    localparam int WAIT_CYC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req, wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack, err, busy;
    logic [DATA_W-1:0] rdata;

    logic              req0, wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0, err0, busy0;
    logic [DATA_W-1:0] rdata0;

    cpu_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    cpu_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(0)
    ) dut0 (
        .clk(clk), .rst(rst), .req(req0), .wr(wr0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word store plus the read data the DUT should be holding.
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] ref_rdata;

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                ack_cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [ADDR_W-1:0] pool [0:12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got ack=1 at cycle %0d, expected no pending transaction", cyc);
            end else begin
                e = exp_q.pop_front();
                check("ack_cycle", cyc, e.ack_cyc);
                check("err", {31'd0, err}, {31'd0, e.err});
                check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
                check("busy_during_ack", {31'd0, busy}, 32'd1);
                $display("txn %s addr=0x%02h rdata=0x%04h err=%0d cycle=%0d",
                         e.is_wr ? "WR" : "RD", e.addr, rdata, err, cyc);
            end
        end
    end

    // Issue one transaction to the main DUT and hold garbage (including req
    // and wr) on the inputs while the request is in flight.
    task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        e.is_wr   = w;
        e.addr    = a;
        e.ack_cyc = cyc + WAIT_CYC + 2;
        if (int'(a) < DEPTH) begin
            e.err = 1'b0;
            if (w) ref_mem[a] = d;
            else   ref_rdata  = ref_mem[a];
        end else begin
            e.err     = 1'b1;
            ref_rdata = '0;
        end
        e.rdata = ref_rdata;
        exp_q.push_back(e);
        for (int i = 0; i <= WAIT_CYC; i++) begin
            @(negedge clk);
            req = 1'b1; wr = 1'b1; addr = 8'($urandom); wdata = 16'($urandom);
        end
        @(negedge clk);
        req = 1'b0; wr = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
    endtask

    task automatic issue0(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        @(negedge clk);
        req0 = 1'b0;
        check("dut0_no_ack_in_resp", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        check("dut0_ack", {31'd0, ack0}, 32'd1);
    endtask

    initial begin
        bit                exp_ack [0:5];
        logic [DATA_W-1:0] exp_rd  [0:5];
        int                idx;

        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_rd  = '{16'h0, 16'h1111, 16'h0, 16'h2222, 16'h0, 16'h0};
        pool    = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h0A, 8'h50, 8'hC7, 8'hC8, 8'hD0};
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_rdata = '0;
        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;

        // Reset, idle inputs.
        repeat (2) @(negedge clk);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdata", {16'd0, rdata}, 32'd0);
        check("reset_rdata0", {16'd0, rdata0}, 32'd0);
        rst = 1'b1;

        // Give every in-range pool address a known value.
        for (int i = 0; i < 11; i++) issue(1'b1, pool[i], 16'($urandom));

        // Write then read back; out-of-range write/read; in-range read after.
        issue(1'b1, 8'h05, 16'hA53C);
        issue(1'b0, 8'h05, 16'h0);
        issue(1'b1, 8'hD0, 16'hFFFF);
        issue(1'b0, 8'hD0, 16'h0);
        issue(1'b0, 8'h50, 16'h0);
        issue(1'b0, 8'h06, 16'h0);

        // Reset while a write is waiting: no ack, memory unchanged.
        issue(1'b1, 8'h0A, 16'h0000);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 8'h0A; wdata = 16'h1234;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        check("wait_busy_before_reset", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        ref_rdata = '0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_ack", {31'd0, ack}, 32'd0);
        check("midreset_rdata", {16'd0, rdata}, 32'd0);
        repeat (4) @(negedge clk);
        issue(1'b0, 8'h0A, 16'h0);

        // Zero wait states, req held across two reads.
        issue0(1'b1, 8'h01, 16'h1111);
        issue0(1'b1, 8'h02, 16'h2222);
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) addr0 = 8'h02;
            if (k == 2) req0 = 1'b0;
            check($sformatf("b2b_ack_%0d", k), {31'd0, ack0}, {31'd0, exp_ack[k]});
            if (exp_ack[k]) begin
                check($sformatf("b2b_rdata_%0d", k), {16'd0, rdata0}, {16'd0, exp_rd[k]});
                check($sformatf("b2b_err_%0d", k), {31'd0, err0}, 32'd0);
            end
            if (k == 2) check("b2b_busy_kept", {31'd0, busy0}, 32'd1);
            if (k == 4) check("b2b_busy_clear", {31'd0, busy0}, 32'd0);
        end

        // Randomized traffic over the address pool, with idle gaps.
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 12);
            issue(1'($urandom), pool[idx], 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
